// File: rtl/sys_defs.sv
// ============================================================================
// Module      : sys_defs
// Description : Shared constants and types for the fetch pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sys_defs;

    localparam logic [31:0] C_NOP_INST = 32'h0000_0013;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } if_state_t;

endpackage

`default_nettype wire

// File: rtl/if_out_buf.sv
// ============================================================================
// Module      : if_out_buf
// Description : One-entry IR/PC output register with load, consume and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_out_buf
    import sys_defs::*;
#(
    parameter logic [31:0] NOP_INST = C_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        consume,
    input  logic        flush,
    input  logic [31:0] load_ir,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic [31:0] npc
);

    logic        r_valid;
    logic [31:0] r_ir;
    logic [31:0] r_pc;
    logic [31:0] r_npc;

    // IR itself reverts to NOP when empty so the output needs no mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ir    <= NOP_INST;
            r_pc    <= 32'h0000_0000;
            r_npc   <= 32'h0000_0004;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ir    <= NOP_INST;
        end else if (load) begin
            r_valid <= 1'b1;
            r_ir    <= load_ir;
            r_pc    <= load_pc;
            r_npc   <= load_pc + 32'd4;
        end else if (consume) begin
            r_valid <= 1'b0;
            r_ir    <= NOP_INST;
        end
    end

    assign valid = r_valid;
    assign ir    = r_ir;
    assign pc    = r_pc;
    assign npc   = r_npc;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : Instruction fetch stage: request FSM, PC and output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
    import sys_defs::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC,
    parameter logic [31:0] NOP_INST = C_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_take_branch,
    input  logic [31:0] ex_target_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_IR,
    output logic [31:0] if_PC,
    output logic [31:0] if_NPC,
    output logic        if_valid_inst
);

    if_state_t   r_state;
    if_state_t   w_next_state;
    logic [31:0] r_pc;
    logic        r_squash;
    logic        w_accept;
    logic        w_capture;
    logic        w_consume;

    assign w_accept  = imem_req && imem_rdy;
    assign w_capture = (r_state == WAIT) && imem_rvalid && !r_squash && !ex_take_branch;
    assign w_consume = if_valid_inst && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A redirect in WAIT with no data yet keeps waiting (squashed) so the
    // stale response drains before a new request goes out.
    always_comb begin
        w_next_state = r_state;
        if (ex_take_branch) begin
            w_next_state = ((r_state == WAIT) && !imem_rvalid) ? WAIT : REQ;
        end else begin
            case (r_state)
                REQ:     if (w_accept) w_next_state = WAIT;
                WAIT:    if (imem_rvalid) w_next_state = (w_capture && stall) ? HOLD : REQ;
                HOLD:    if (!stall) w_next_state = REQ;
                default: w_next_state = REQ;
            endcase
        end
    end

    always_comb begin
        imem_req = 1'b0;
        if ((r_state == REQ) && !rst && !ex_take_branch && !(if_valid_inst && stall)) begin
            imem_req = 1'b1;
        end
    end

    assign imem_addr = r_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC & 32'hFFFF_FFFC;
        end else if (ex_take_branch) begin
            r_pc <= ex_target_pc & 32'hFFFF_FFFC;
        end else if (w_capture) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_squash <= 1'b0;
        end else if (r_state == WAIT) begin
            if (imem_rvalid) begin
                r_squash <= 1'b0;
            end else if (ex_take_branch) begin
                r_squash <= 1'b1;
            end
        end else begin
            r_squash <= 1'b0;
        end
    end

    if_out_buf #(
        .NOP_INST (NOP_INST)
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (w_capture),
        .consume (w_consume),
        .flush   (ex_take_branch),
        .load_ir (imem_rdata),
        .load_pc (imem_addr),
        .valid   (if_valid_inst),
        .ir      (if_IR),
        .pc      (if_PC),
        .npc     (if_NPC)
    );

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_take_branch;
    logic [31:0] ex_target_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_IR;
    logic [31:0] if_PC;
    logic [31:0] if_NPC;
    logic        if_valid_inst;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] fetch_log[$];
    logic [31:0] pend[$];
    bit          resp_ok;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .ex_take_branch (ex_take_branch),
        .ex_target_pc   (ex_target_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdy       (imem_rdy),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_IR          (if_IR),
        .if_PC          (if_PC),
        .if_NPC         (if_NPC),
        .if_valid_inst  (if_valid_inst)
    );

    always #5 clk = ~clk;

    // Memory content: instruction word = address ^ 32'hC0DE_0000.
    task automatic cycle();
        bit          acc;
        logic [31:0] a;
        #2;
        acc = imem_req && imem_rdy;
        a   = imem_addr;
        @(posedge clk);
        #1;
        if (acc) begin
            fetch_log.push_back(a);
            pend.push_back(a);
        end
        if (resp_ok && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend.pop_front() ^ 32'hC0DE_0000;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; ex_take_branch = 1'b0; ex_target_pc = 32'h0;
        imem_rdy = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0; resp_ok = 1'b1;
        fetch_log.delete(); pend.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; ex_take_branch = 1'b0; ex_target_pc = 32'h0;
        imem_rdy = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0; resp_ok = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (if_valid_inst !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", if_valid_inst); end
        checks++; if (if_IR !== 32'h0000_0013) begin errors++; $display("FAIL rst_ir: got %h exp 00000013", if_IR); end
        checks++; if (if_PC !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h exp 00000000", if_PC); end
        checks++; if (if_NPC !== 32'h4) begin errors++; $display("FAIL rst_npc: got %h exp 00000004", if_NPC); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end
        rst = 1'b0; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_first_req: got req=%b addr=%h exp 1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        do_reset();
        cycle();
        checks++; if (if_valid_inst !== 1'b0) begin errors++; $display("FAIL seq_latency: got valid=%b exp 0", if_valid_inst); end
        cycle();
        checks++; if (if_valid_inst !== 1'b1 || if_PC !== 32'h0 || if_IR !== 32'hC0DE_0000 || if_NPC !== 32'h4) begin
            errors++; $display("FAIL seq_pc0: got v=%b pc=%h ir=%h npc=%h exp 1/00000000/c0de0000/00000004", if_valid_inst, if_PC, if_IR, if_NPC); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr4: got req=%b addr=%h exp 1/00000004", imem_req, imem_addr); end
        cycle(); cycle();
        checks++; if (if_valid_inst !== 1'b1 || if_PC !== 32'h4 || if_IR !== 32'hC0DE_0004) begin
            errors++; $display("FAIL seq_pc4: got v=%b pc=%h ir=%h exp 1/00000004/c0de0004", if_valid_inst, if_PC, if_IR); end
        cycle(); cycle();
        checks++; if (if_valid_inst !== 1'b1 || if_PC !== 32'h8 || if_NPC !== 32'hC) begin
            errors++; $display("FAIL seq_pc8: got v=%b pc=%h npc=%h exp 1/00000008/0000000c", if_valid_inst, if_PC, if_NPC); end
        checks++; if (fetch_log.size() != 3 || fetch_log[0] !== 32'h0 || fetch_log[1] !== 32'h4 || fetch_log[2] !== 32'h8) begin
            errors++; $display("FAIL seq_log: got n=%0d exp 3 fetches 0,4,8", fetch_log.size()); end
    endtask

    task automatic test_stall_hold();
        do_reset();
        ex_take_branch = 1'b1; ex_target_pc = 32'h10; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_gate: got %b exp 0", imem_req); end
        cycle();
        ex_take_branch = 1'b0; stall = 1'b1;
        cycle(); cycle();
        for (int i = 0; i < 5; i++) begin
            checks++; if (if_valid_inst !== 1'b1 || if_PC !== 32'h10 || if_IR !== 32'hC0DE_0010 || imem_req !== 1'b0) begin
                errors++; $display("FAIL hold_%0d: got v=%b pc=%h ir=%h req=%b exp 1/00000010/c0de0010/0", i, if_valid_inst, if_PC, if_IR, imem_req); end
            cycle();
        end
        stall = 1'b0; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_release_req: got %b exp 0", imem_req); end
        cycle();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14 || if_valid_inst !== 1'b0) begin
            errors++; $display("FAIL hold_next: got req=%b addr=%h v=%b exp 1/00000014/0", imem_req, imem_addr, if_valid_inst); end
        checks++; if (fetch_log.size() != 1) begin errors++; $display("FAIL hold_nodup: got %0d fetches exp 1", fetch_log.size()); end
    endtask

    task automatic test_squash();
        do_reset();
        ex_take_branch = 1'b1; ex_target_pc = 32'h20;
        cycle();
        ex_take_branch = 1'b0; resp_ok = 1'b0;
        cycle();
        ex_take_branch = 1'b1; ex_target_pc = 32'h100; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sq_wait_req: got %b exp 0", imem_req); end
        cycle();
        ex_take_branch = 1'b0; resp_ok = 1'b1; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sq_still_wait: got req=%b exp 0", imem_req); end
        cycle();
        cycle();
        checks++; if (if_valid_inst !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL sq_discard: got v=%b req=%b addr=%h exp 0/1/00000100", if_valid_inst, imem_req, imem_addr); end
        cycle(); cycle();
        checks++; if (if_valid_inst !== 1'b1 || if_PC !== 32'h100 || if_IR !== 32'hC0DE_0100) begin
            errors++; $display("FAIL sq_target: got v=%b pc=%h ir=%h exp 1/00000100/c0de0100", if_valid_inst, if_PC, if_IR); end
    endtask

    task automatic test_redirect();
        // redirect coincident with rvalid
        do_reset();
        cycle();
        ex_take_branch = 1'b1; ex_target_pc = 32'h40;
        cycle();
        ex_take_branch = 1'b0; #1;
        checks++; if (if_valid_inst !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            errors++; $display("FAIL redir_rvalid: got v=%b req=%b addr=%h exp 0/1/00000040", if_valid_inst, imem_req, imem_addr); end
        // redirect with full buffer and stall
        do_reset();
        stall = 1'b1;
        cycle(); cycle();
        checks++; if (if_valid_inst !== 1'b1 || if_PC !== 32'h0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL redir_full: got v=%b pc=%h req=%b exp 1/00000000/0", if_valid_inst, if_PC, imem_req); end
        ex_take_branch = 1'b1; ex_target_pc = 32'h203;
        cycle();
        ex_take_branch = 1'b0; #1;
        checks++; if (if_valid_inst !== 1'b0 || if_IR !== 32'h0000_0013 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++; $display("FAIL redir_flush: got v=%b ir=%h req=%b addr=%h exp 0/00000013/1/00000200", if_valid_inst, if_IR, imem_req, imem_addr); end
    endtask

    task automatic test_rdy_low();
        do_reset();
        imem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_log.size() != 0) begin
                errors++; $display("FAIL rdy_low_%0d: got req=%b addr=%h n=%0d exp 1/00000000/0", i, imem_req, imem_addr, fetch_log.size()); end
        end
        imem_rdy = 1'b1;
        cycle(); cycle();
        checks++; if (if_valid_inst !== 1'b1 || if_PC !== 32'h0 || fetch_log.size() != 1) begin
            errors++; $display("FAIL rdy_fetch: got v=%b pc=%h n=%0d exp 1/00000000/1", if_valid_inst, if_PC, fetch_log.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        ex_take_branch = 1'b1; ex_target_pc = 32'hFFFF_FFFF;
        cycle();
        ex_take_branch = 1'b0; #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h exp fffffffc", imem_addr); end
        cycle(); cycle();
        checks++; if (if_PC !== 32'hFFFF_FFFC || if_NPC !== 32'h0 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_next: got pc=%h npc=%h addr=%h exp fffffffc/00000000/00000000", if_PC, if_NPC, imem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        ex_take_branch = 1'b1; ex_target_pc = 32'h80;
        cycle();
        ex_take_branch = 1'b0; resp_ok = 1'b0;
        cycle();
        rst = 1'b1; #1;
        checks++; if (imem_req !== 1'b0 || if_valid_inst !== 1'b0 || if_NPC !== 32'h4) begin
            errors++; $display("FAIL arst: got req=%b v=%b npc=%h exp 0/0/00000004", imem_req, if_valid_inst, if_NPC); end
        cycle();
        rst = 1'b0; imem_rdy = 1'b0; resp_ok = 1'b1; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL arst_first: got req=%b addr=%h exp 1/00000000", imem_req, imem_addr); end
        cycle(); cycle();
        checks++; if (if_valid_inst !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL late_rvalid: got v=%b req=%b addr=%h exp 0/1/00000000", if_valid_inst, imem_req, imem_addr); end
        imem_rdy = 1'b1;
        cycle(); cycle();
        checks++; if (if_valid_inst !== 1'b1 || if_PC !== 32'h0 || if_IR !== 32'hC0DE_0000) begin
            errors++; $display("FAIL arst_refetch: got v=%b pc=%h ir=%h exp 1/00000000/c0de0000", if_valid_inst, if_PC, if_IR); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_squash();
        test_redirect();
        test_rdy_low();
        test_wrap();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), driven on if_IR when no valid instruction.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 rst  in  1  system reset, asynchronous, active-high.
REQ-005 stall  in  1  hazard stall from decode; ID holds its instruction while high.
REQ-006 ex_take_branch  in  1  redirect request (taken branch/jump).
REQ-007 ex_target_pc  in  32  redirect target.
REQ-008 imem_req  out  1  fetch request valid.
REQ-009 imem_addr  out  32  word-aligned fetch address.
REQ-010 imem_rdy  in  1  memory accepts request this cycle when imem_req high.
REQ-011 imem_rvalid  in  1  read data valid.
REQ-012 imem_rdata  in  32  fetched instruction.
REQ-013 if_IR  out  32  instruction to the IF/ID register.
REQ-014 if_PC  out  32  PC of if_IR.
REQ-015 if_NPC  out  32  if_PC+4.
REQ-016 if_valid_inst  out  1  if_IR/if_PC valid.

Function
REQ-017 The FSM SHALL have states REQ (imem_req=1, imem_addr=pc_q), WAIT (request outstanding, imem_req=0) and HOLD (output buffer full and stalled, imem_req=0).
REQ-018 REQ->WAIT on imem_req&imem_rdy; REQ stays otherwise.
REQ-019 WAIT on imem_rvalid: non-squashed data SHALL be written to a one-entry output buffer (IR, PC) with pc_q<=pc_q+4; next state REQ, or HOLD if the buffer stays full (stall high).
REQ-020 HOLD->REQ in the first cycle stall is low (buffer consumed).
REQ-021 At most one request SHALL be outstanding; a new request SHALL NOT be issued while the buffer is full and stall high.
REQ-022 The buffer SHALL be consumed on any cycle with if_valid_inst=1 and stall=0; a same-cycle rvalid capture then refills it (no bubble, no loss).
REQ-023 if_IR=buffer IR when valid else NOP_INST; if_PC/if_NPC from buffer; outputs driven directly from registers.
REQ-024 Minimum latency: request accepted cycle N, rvalid N+1, if_valid_inst high N+2.
REQ-025 ex_take_branch SHALL take priority over stall and all FSM transitions: buffer invalidated, pc_q<={ex_target_pc[31:2],2'b00}, next state REQ.
REQ-026 Redirect in WAIT SHALL set a squash flag; the following rvalid is discarded, clears the flag, pc_q unchanged; next state REQ.
REQ-027 Redirect coincident with rvalid SHALL discard that data.
REQ-028 imem_addr[1:0] SHALL always be 2'b00; pc_q+4 wraps modulo 2^32.
REQ-029 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-030 On rst assertion, asynchronously: pc_q=RESET_PC, state=REQ, buffer invalid, squash=0.
REQ-031 During reset outputs SHALL be if_valid_inst=0, if_IR=NOP_INST, if_PC=0, if_NPC=4, imem_req=0.
REQ-032 Reset mid-request SHALL abandon the outstanding fetch; the first post-reset request is at RESET_PC in the cycle after deassertion.

Structure
REQ-033 NOP_INST, default RESET_PC and the enum if_state_t {REQ,WAIT,HOLD} SHALL live in the shared sys_defs package.
REQ-034 One sub-module if_out_buf (one-entry IR/PC register with load/consume/flush) SHALL be used; FSM and PC logic stay in if_stage.

Verification
REQ-035 Reset release, imem_rdy=1, rvalid one cycle after accept, stall=0 -> addresses 0,4,8 fetched; if_PC 0,4,8 at two-cycle spacing.
REQ-036 Buffer holds PC=0x10 with stall high 5 cycles -> if_IR/if_PC constant, imem_req=0; stall low -> next request 0x14 the following cycle.
REQ-037 Redirect to 0x100 while WAIT for 0x20 -> 0x20 data discarded (if_valid_inst=0), next request 0x100, if_PC=0x100.
REQ-038 Redirect to 0x203 concurrent with stall and full buffer -> buffer flushed, imem_addr=0x200.
REQ-039 imem_rdy low 3 cycles -> imem_req/imem_addr stable, no duplicate fetch.
REQ-040 rst asserted mid-WAIT, late rvalid after release -> ignored, first fetch at RESET_PC.
